somador_serial: RTL and testbench
=================================

# somador_serial

Bit-serial N-bit adder: sums two N-bit operands plus carry-in LSB-first through one full-adder cell, one bit per clock. It is the sequential addition counterpart of the full-subtractor cell in the arithmetic circuit set. It gives a small-area adder for the multi-cycle datapath exercises, with a start/busy/done handshake toward the controlling logic.

## Interface
- `N`, default 8: operand and result width; N ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new addition; sampled only when not busy.
- `a`  in  N  operand A; captured at the accepting edge.
- `b`  in  N  operand B; captured at the accepting edge.
- `cin`  in  1  carry-in; captured at the accepting edge.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; result valid.
- `soma`  out  N  sum (a + b + cin) mod 2^N.
- `cout`  out  1  carry out of bit N-1.
- `ovf`  out  1  signed overflow; present only with `SOMADOR_SERIAL_OVF_EN`.

## Operation
- One clock domain; reset is asynchronous and active-low.
- Reset values: state IDLE; `busy`=0, `done`=0, `soma`=0, `cout`=0, `ovf`=0; internal shift registers, carry flop and bit counter = 0.
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - `start`=1 at an edge: load `a` and `b` into shift registers, load the carry flop from `cin`, clear the counter.
  - Go to SHIFT; `busy`=1.
- **SHIFT**, one bit per cycle:
  - Full adder takes the LSB of A, the LSB of B and the carry flop.
  - The sum bit shifts into the MSB of the internal result register; the A/B registers shift right.
  - The carry flop takes the carry out; the counter increments.
  - After the N-th bit: go to DONE.
  - In the same edge, copy the internal result to `soma` and the carry flop's new value to `cout`.
  - `done`=1 and `busy`=0.
- **DONE**, one cycle:
  - `done` drops at the next edge.
  - `start`=1 in DONE is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- `soma`/`cout`/`ovf` update only at completion. They hold their value until the next completion and never expose partial sums.
- `start` during SHIFT is ignored and not queued. Operand changes after the accepting edge have no effect.
- Width rule: the result is modulo 2^N; the carry beyond bit N-1 appears only on `cout`.
- `rst_n` low at any time, including mid-operation:
  - Immediate return to reset values; the operation is discarded.
  - No `done` pulse for the aborted operation.

## Timing
- Accepting edge = E0.
- `busy` is high from E0 until E(N).
- `done`, `soma`, `cout` and `ovf` register at E(N) and are high/valid during the cycle E(N)→E(N+1).
- Latency from accepting edge to `done`: N cycles.
- Throughput: one operation every N+1 cycles when `start` is held high, or N+1 with `start` asserted in DONE.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: `SOMADOR_SERIAL_OVF_EN`.
- **Defined:**
  - Port `ovf` exists.
  - `ovf` = carry into bit N-1 XOR carry out of bit N-1. The carry into bit N-1 is captured from the carry flop when bit N-1 is processed.
  - `ovf` is registered at E(N) alongside `soma` and cleared by reset.
- **Undefined:** no `ovf` port, no extra flop; all other behaviour is identical.

## Structure
- Shared include `somador_serial_defs.vh`:
  - State encodings `ST_IDLE`=2'd0, `ST_SHIFT`=2'd1, `ST_DONE`=2'd2.
  - Default width constant.
- Counter width: clog2(N+1), computed locally.
- Sub-module `somadorcompleto_struct`:
  - Structural full adder with ports `a`, `b`, `carry_in`, `soma`, `carry_out`.
  - One instance is the only arithmetic in the block.

## Test plan
- N=8, `a`=0x2C, `b`=0x13, `cin`=0 → `done` exactly 8 cycles after accept; `soma`=0x3F, `cout`=0, `ovf`=0.
- `a`=0xFF, `b`=0x01, `cin`=0 → `soma`=0x00, `cout`=1, `ovf`=0. Also `a`=0xFF, `b`=0x00, `cin`=1 → same result.
- `a`=0x7F, `b`=0x01 → `soma`=0x80, `cout`=0, `ovf`=1 (macro on). Also `a`=0x80, `b`=0x80 → `soma`=0x00, `cout`=1, `ovf`=1.
- `start` pulsed again 3 cycles into an operation with different operands → ignored; the first result is returned and `busy` is unchanged.
- `start` held high: 0x01+0x01, then 0x10+0x20 → `done` pulses 9 cycles apart with results 0x02 then 0x30; `soma` holds 0x02 between the pulses.
- `rst_n` low for 1 cycle at cycle 4 of an operation → all outputs 0, no `done`. A new `start` afterwards completes normally.

Source files
------------

// File: rtl/somador_serial_pkg.sv
// Shared types and constants for the bit-serial adder.
package somador_serial_pkg;

   localparam int unsigned SomadorDefWidth = 8;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StDone  = 2'd2
   } somador_state_e;

endpackage

// File: rtl/somadorcompleto_struct.sv
// Structural one-bit full adder: the only arithmetic cell of the serial adder.
module somadorcompleto_struct (
   input  logic a,
   input  logic b,
   input  logic carry_in,
   output logic soma,
   output logic carry_out
);

   logic prop;
   logic gen;
   logic prop_c;

   assign prop      = a ^ b;
   assign gen       = a & b;
   assign prop_c    = prop & carry_in;
   assign soma      = prop ^ carry_in;
   assign carry_out = gen | prop_c;

endmodule

// File: rtl/somador_serial.sv
// Bit-serial N-bit adder, LSB first, one bit per clock with start/busy/done handshake.
// Define SOMADOR_SERIAL_OVF_EN to add the registered signed-overflow output ovf.
module somador_serial
   import somador_serial_pkg::*;
#(
   parameter int unsigned N = SomadorDefWidth
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] soma,
`ifdef SOMADOR_SERIAL_OVF_EN
   output logic         ovf,
`endif
   output logic         cout
);

   localparam int unsigned CntW = $clog2(N + 1);
   localparam logic [CntW-1:0] LastBit = CntW'(N - 1);

   somador_state_e state_q, state_d;
   logic [N-1:0]    a_q, a_d;
   logic [N-1:0]    b_q, b_d;
   logic [N-1:0]    acc_q, acc_d;
   logic [N-1:0]    soma_q, soma_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            carry_q, carry_d;
   logic            cout_q, cout_d;
`ifdef SOMADOR_SERIAL_OVF_EN
   logic            ovf_q, ovf_d;
`endif

   logic fa_sum;
   logic fa_carry;

   somadorcompleto_struct u_fa (
      .a         (a_q[0]),
      .b         (b_q[0]),
      .carry_in  (carry_q),
      .soma      (fa_sum),
      .carry_out (fa_carry)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      soma_d  = soma_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
`ifdef SOMADOR_SERIAL_OVF_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         // DONE accepts a new request exactly like IDLE for back-to-back use
         StIdle, StDone: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = StShift;
            end else begin
               state_d = StIdle;
            end
         end
         StShift: begin
            a_d     = {1'b0, a_q[N-1:1]};
            b_d     = {1'b0, b_q[N-1:1]};
            acc_d   = {fa_sum, acc_q[N-1:1]};
            carry_d = fa_carry;
            cnt_d   = cnt_q + CntW'(1);
            if (cnt_q == LastBit) begin
               state_d = StDone;
               soma_d  = {fa_sum, acc_q[N-1:1]};
               cout_d  = fa_carry;
`ifdef SOMADOR_SERIAL_OVF_EN
               // carry_q is the carry into the MSB while it is being added
               ovf_d   = carry_q ^ fa_carry;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         soma_q  <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
`ifdef SOMADOR_SERIAL_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         soma_q  <= soma_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
`ifdef SOMADOR_SERIAL_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = (state_q == StShift);
   assign done = (state_q == StDone);
   assign soma = soma_q;
   assign cout = cout_q;
`ifdef SOMADOR_SERIAL_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_somador_serial.sv
// Directed bench for somador_serial (N=8); ovf is checked when SOMADOR_SERIAL_OVF_EN is set.
module tb_somador_serial;

   localparam int unsigned N = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [N-1:0] soma;
   logic         cout;
`ifdef SOMADOR_SERIAL_OVF_EN
   logic         ovf;
`endif

   int tests;
   int fails;

   somador_serial #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .soma  (soma),
`ifdef SOMADOR_SERIAL_OVF_EN
      .ovf   (ovf),
`endif
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_result(input string tag, input logic [N-1:0] es, input logic ec,
                             input logic eo);
      chk({tag, " soma"}, 32'(soma), 32'(es));
      chk({tag, " cout"}, 32'(cout), 32'(ec));
`ifdef SOMADOR_SERIAL_OVF_EN
      chk({tag, " ovf"}, 32'(ovf), 32'(eo));
`else
      if (eo === 1'bx) $display("unused overflow expectation");
`endif
   endtask

   // Called #1 after an edge; returns at E0 + 1.
   task automatic start_op(input logic [N-1:0] va, input logic [N-1:0] vb, input logic vc);
      a     = va;
      b     = vb;
      cin   = vc;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy after accept", 32'(busy), 32'd1);
   endtask

   // Counts edges since E0 until done is seen; bounded.
   task automatic wait_done(input int from, output int lat);
      lat = from;
      while (lat < int'(N) + 4) begin
         @(posedge clk);
         #1;
         lat++;
         if (done) break;
      end
   endtask

   task automatic op(input string tag, input logic [N-1:0] va, input logic [N-1:0] vb,
                     input logic vc, input logic [N-1:0] es, input logic ec, input logic eo);
      int lat;
      start_op(va, vb, vc);
      wait_done(0, lat);
      chk({tag, " latency"}, 32'(lat), 32'(N));
      chk({tag, " busy in done"}, 32'(busy), 32'd0);
      chk_result(tag, es, ec, eo);
      @(posedge clk);
      #1;
      chk({tag, " done drops"}, 32'(done), 32'd0);
      chk_result({tag, " hold"}, es, ec, eo);
   endtask

   initial begin
      int lat;
      int k;
      int seen;
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk_result("reset", 8'h00, 1'b0, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      op("2c+13", 8'h2C, 8'h13, 1'b0, 8'h3F, 1'b0, 1'b0);
      op("ff+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      op("ff+00+c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
      op("7f+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      op("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      op("a5+5a+c", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);

      // start during SHIFT must be ignored
      start_op(8'h05, 8'h03, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      a     = 8'hAA;
      b     = 8'h55;
      cin   = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("ignore busy", 32'(busy), 32'd1);
      wait_done(3, lat);
      chk("ignore latency", 32'(lat), 32'(N));
      chk_result("ignore", 8'h08, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("ignore no restart", 32'(busy), 32'd0);
      chk("ignore done drops", 32'(done), 32'd0);

      // start held high: back-to-back operations
      a     = 8'h01;
      b     = 8'h01;
      cin   = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      a = 8'h10;
      b = 8'h20;
      wait_done(0, lat);
      chk("b2b first latency", 32'(lat), 32'(N));
      chk_result("b2b first", 8'h02, 1'b0, 1'b0);
      k = 0;
      while (k < int'(N) + 4) begin
         @(posedge clk);
         #1;
         k++;
         if (done) break;
         chk("b2b soma holds", 32'(soma), 32'h02);
      end
      start = 1'b0;
      chk("b2b spacing", 32'(k), 32'(N + 1));
      chk_result("b2b second", 8'h30, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("b2b idle", 32'(busy), 32'd0);

      // reset in the middle of an operation
      start_op(8'h11, 8'h22, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort busy", 32'(busy), 32'd0);
      chk("abort done", 32'(done), 32'd0);
      chk_result("abort", 8'h00, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (N + 2) begin
         @(posedge clk);
         #1;
         if (done) seen++;
      end
      chk("abort no done", 32'(seen), 32'd0);
      op("after abort", 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
